// File: rtl/axis_rows_resize_pkg.sv
// rtl/axis_rows_resize_pkg.sv - pad source codes and line FSM states for axis_rows_resize
package axis_rows_resize_pkg;

  localparam int PAD_ZERO   = 0;
  localparam int PAD_REPEAT = 1;
  localparam int PAD_CONST  = 2;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_DROP = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

endpackage

// File: rtl/axis_rows_resize_out_reg.sv
// rtl/axis_rows_resize_out_reg.sv - registered AXI-Stream output slice with ready-gated load
module axis_rows_resize_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_user,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_user
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             user_q, user_d;

  // Data is only refreshed with a real beat so an idle slot keeps the last value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    if (load) begin
      valid_d = in_valid;
      last_d  = in_valid & in_last;
      user_d  = in_valid & in_user;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_user  = user_q;

endmodule

// File: rtl/axis_rows_resize.sv
// rtl/axis_rows_resize.sv - forces every AXI-Stream line to rows_size beats by cropping or padding
module axis_rows_resize
  import axis_rows_resize_pkg::*;
#(
  parameter int                DATA_WIDTH = 8,
  parameter int                CHANNELS   = 1,
  parameter int                LEN_WIDTH  = 16,
  parameter int                PAD_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                           pixel_clk,
  input  logic                           reset,
  input  logic [LEN_WIDTH-1:0]           rows_size,
  input  logic [DATA_WIDTH*CHANNELS-1:0] s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tuser,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           line_short,
  output logic                           line_long,
  output logic                           sof_err
);

  localparam int TW = DATA_WIDTH * CHANNELS;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [TW-1:0]        hold_q, hold_d;
  logic                 short_q, short_d;
  logic                 long_q, long_d;
  logic                 sof_q, sof_d;

  logic                 out_load;
  logic                 first_beat;
  logic [LEN_WIDTH-1:0] line_len;
  logic                 at_end;
  logic [TW-1:0]        pad_data;
  logic                 o_valid, o_last, o_user;
  logic [TW-1:0]        o_data;

  assign out_load = ~m_axis_tvalid | m_axis_tready;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PASS;
      cnt_q   <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      short_q <= short_d;
      long_q  <= long_d;
      sof_q   <= sof_d;
    end
  end

  always_comb begin
    pad_data = '0;
    if (PAD_MODE == PAD_REPEAT) pad_data = hold_q;
    else if (PAD_MODE == PAD_CONST) pad_data = {CHANNELS{PAD_VALUE}};
  end

  // On the first beat of a line the live rows_size is used; afterwards the latched length.
  always_comb begin
    first_beat = (cnt_q == '0);
    line_len   = len_q;
    if (first_beat) line_len = (rows_size == '0) ? LEN_WIDTH'(1) : rows_size;
    at_end     = (cnt_q == line_len - LEN_WIDTH'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    hold_d  = hold_q;
    case (state_q)
      ST_PASS: begin
        if (s_axis_tvalid && out_load) begin
          hold_d = s_axis_tdata;
          if (first_beat) len_d = line_len;
          if (at_end) begin
            cnt_d = '0;
            if (!s_axis_tlast) state_d = ST_DROP;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
            if (s_axis_tlast) state_d = ST_PAD;
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_PASS;
      end
      ST_PAD: begin
        if (out_load) begin
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = ST_PASS;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    o_valid       = 1'b0;
    o_data        = s_axis_tdata;
    o_last        = 1'b0;
    o_user        = 1'b0;
    short_d       = 1'b0;
    long_d        = 1'b0;
    sof_d         = 1'b0;
    case (state_q)
      ST_PASS: begin
        s_axis_tready = out_load;
        if (s_axis_tvalid && out_load) begin
          o_valid = 1'b1;
          o_last  = at_end;
          o_user  = first_beat & s_axis_tuser;
          sof_d   = ~first_beat & s_axis_tuser;
          long_d  = at_end & ~s_axis_tlast;
          short_d = ~at_end & s_axis_tlast;
        end
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        sof_d         = s_axis_tvalid & s_axis_tuser;
      end
      ST_PAD: begin
        o_valid = out_load;
        o_data  = pad_data;
        o_last  = (cnt_q == len_q - LEN_WIDTH'(1));
      end
      default: ;
    endcase
  end

  axis_rows_resize_out_reg #(.WIDTH(TW)) u_out_reg (
    .clk      (pixel_clk),
    .rst      (reset),
    .load     (out_load),
    .in_valid (o_valid),
    .in_data  (o_data),
    .in_last  (o_last),
    .in_user  (o_user),
    .out_valid(m_axis_tvalid),
    .out_data (m_axis_tdata),
    .out_last (m_axis_tlast),
    .out_user (m_axis_tuser)
  );

  assign line_short = short_q;
  assign line_long  = long_q;
  assign sof_err    = sof_q;

endmodule
